// File: rtl/powlib_dpram_rdstream.sv
// powlib_dpram_rdstream
// Burst read-out engine for powlib_dpram. Accepts a (start index, length-1)
// request, walks the RAM's combinational read port with index wrap at D-1,
// and streams the words out over a valid/ready interface with a last marker.
// Optional feature: define POWLIB_DPRAM_RDSTREAM_ABORT_EN to let the abort
// input cancel an in-progress burst; otherwise abort is ignored.
module powlib_dpram_rdstream #(
  parameter int W    = 16,
  parameter int D    = 8,
  parameter int WIDX = (D > 1) ? $clog2(D) : 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            reqvld,
  output logic            reqrdy,
  input  logic [WIDX-1:0] reqidx,
  input  logic [WIDX-1:0] reqlen,
  output logic [WIDX-1:0] rdidx,
  input  logic [W-1:0]    rddata,
  output logic [W-1:0]    outdata,
  output logic            outvld,
  input  logic            outrdy,
  output logic            outlast,
  output logic            busy,
  input  logic            abort
);

  typedef enum logic [1:0] {
    IDLE,
    READ,
    DRAIN
  } state_t;

  localparam logic [WIDX-1:0] LAST_IDX = WIDX'(D - 1);

  state_t          state;
  logic [WIDX-1:0] cur;
  logic [WIDX-1:0] rem;
  logic            load;
  logic            handshake;
  logic            abort_hit;

  // The output register may take a new word when it is empty or being drained
  assign load      = (state == READ) && (!outvld || outrdy);
  assign handshake = outvld && outrdy;

`ifdef POWLIB_DPRAM_RDSTREAM_ABORT_EN
  assign abort_hit = abort && (state != IDLE);
`else
  logic unused_abort;
  assign unused_abort = abort;
  assign abort_hit    = 1'b0;
`endif

  // Burst sequencer: index/remaining-count tracking and the output register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      cur     <= '0;
      rem     <= '0;
      outdata <= '0;
      outvld  <= 1'b0;
      outlast <= 1'b0;
    end else if (abort_hit) begin
      // A coinciding handshake is simply treated as consumed; the burst ends.
      state   <= IDLE;
      outvld  <= 1'b0;
      outlast <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (reqvld) begin
            cur   <= reqidx;
            rem   <= reqlen;
            state <= READ;
          end
        end
        READ: begin
          if (load) begin
            outdata <= rddata;
            outvld  <= 1'b1;
            outlast <= (rem == '0);
            if (rem != '0) begin
              cur <= (cur == LAST_IDX) ? '0 : cur + 1'b1;
              rem <= rem - 1'b1;
            end else begin
              state <= DRAIN;
            end
          end
        end
        DRAIN: begin
          if (handshake) begin
            outvld  <= 1'b0;
            outlast <= 1'b0;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // The read index tracks cur, which only moves on accepts and loads
  assign rdidx  = cur;
  assign reqrdy = (state == IDLE);
  assign busy   = (state != IDLE);

endmodule
